// File: rtl/sdram_glue_pkg.sv
// Shared constants and state encoding for the SDRAM request/done glue.
package sdram_glue_pkg;
    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BURST  = 4;

    localparam int unsigned GRAM_BASE = 0;
    localparam int unsigned RING_BASE = 384000;
    localparam int unsigned RING_END  = 386396;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StCmd   = 3'd1,
        StWbeat = 3'd2,
        StRwait = 3'd3,
        StDone  = 3'd4
    } resp_state_e;
endpackage

// File: rtl/sdram_rr_arbiter.sv
// Two-way round-robin pick between read and write requests; write wins first after reset.
module sdram_rr_arbiter (
    input  logic clk,
    input  logic rst_n,
    input  logic rd_req,
    input  logic wr_req,
    input  logic accept,
    output logic grant_wr
);
    logic prefer_wr_q;

    always_comb begin
        if (rd_req && wr_req) grant_wr = prefer_wr_q;
        else                  grant_wr = wr_req;
    end

    // Pointer always names the type that was not served last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      prefer_wr_q <= 1'b1;
        else if (accept) prefer_wr_q <= ~grant_wr;
    end
endmodule

// File: rtl/sdram_burst_responder.sv
// SDRAM burst responder: one 4-beat read or write burst per level-held client request.
// Optional cycle watchdog and oTimeout_Err port are enabled by defining SDRAM_RESP_TIMEOUT_EN.
module sdram_burst_responder #(
`ifdef SDRAM_RESP_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYC = 1023,
`endif
    parameter int unsigned ADDR_W = sdram_glue_pkg::ADDR_W,
    parameter int unsigned DATA_W = sdram_glue_pkg::DATA_W,
    parameter int unsigned BURST  = sdram_glue_pkg::BURST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iRd_Req,
    input  logic [ADDR_W-1:0] iRd_Addr,
    output logic [DATA_W-1:0] oRd_Data1,
    output logic [DATA_W-1:0] oRd_Data2,
    output logic [DATA_W-1:0] oRd_Data3,
    output logic [DATA_W-1:0] oRd_Data4,
    output logic              oRd_Done,
    input  logic              iWr_Req,
    input  logic [ADDR_W-1:0] iWr_Addr,
    input  logic [DATA_W-1:0] iWr_Data1,
    input  logic [DATA_W-1:0] iWr_Data2,
    input  logic [DATA_W-1:0] iWr_Data3,
    input  logic [DATA_W-1:0] iWr_Data4,
    output logic              oWr_Done,
    output logic              oCmd_Valid,
    input  logic              iCmd_Ready,
    output logic              oCmd_Write,
    output logic [ADDR_W-1:0] oCmd_Addr,
    output logic [DATA_W-1:0] oWr_Beat_Data,
    input  logic              iWr_Beat_Ready,
    input  logic              iRd_Beat_Valid,
    input  logic [DATA_W-1:0] iRd_Beat_Data,
    output logic              oBusy,
`ifdef SDRAM_RESP_TIMEOUT_EN
    output logic              oTimeout_Err,
`endif
    output logic              oAlign_Err
);
    import sdram_glue_pkg::*;

    resp_state_e       state_q, state_d;
    logic              grant_wr, accept, last_beat, busy_run, wd_expire;
    logic [ADDR_W-1:0] req_addr;
    logic              cmd_write_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [1:0]        beat_q, beat_d;
    logic [DATA_W-1:0] wr_words_q [4];
    logic [DATA_W-1:0] rd_buf_q   [4];
    logic [DATA_W-1:0] rd_buf_d   [4];
    logic [DATA_W-1:0] rd_out_q   [4];
    logic              align_err_q;

    assign accept    = (state_q == StIdle) && (iRd_Req || iWr_Req);
    assign req_addr  = grant_wr ? iWr_Addr : iRd_Addr;
    assign last_beat = (beat_q == 2'(BURST - 1));
    assign busy_run  = state_q inside {StCmd, StWbeat, StRwait};

    sdram_rr_arbiter u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_req   (iRd_Req),
        .wr_req   (iWr_Req),
        .accept   (accept),
        .grant_wr (grant_wr)
    );

`ifdef SDRAM_RESP_TIMEOUT_EN
    localparam int unsigned WdW = ($clog2(TIMEOUT_CYC + 1) > 10) ? $clog2(TIMEOUT_CYC + 1) : 10;

    logic [WdW-1:0] wd_q;
    logic           timeout_err_q;

    // Fires on the TIMEOUT_CYC-th cycle spent outside IDLE/DONE for this request.
    assign wd_expire = busy_run && (wd_q == WdW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q          <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wd_q <= busy_run ? wd_q + 1'b1 : '0;
            if (wd_expire) timeout_err_q <= 1'b1;
        end
    end

    assign oTimeout_Err = timeout_err_q;
`else
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        rd_buf_d = rd_buf_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d  = StCmd;
                    beat_d   = '0;
                    // Cleared so a timed-out read reports 0 for missing words.
                    rd_buf_d = '{default: '0};
                end
            end
            StCmd: begin
                if (iCmd_Ready) begin
                    state_d = cmd_write_q ? StWbeat : StRwait;
                    beat_d  = '0;
                end
            end
            StWbeat: begin
                if (iWr_Beat_Ready) begin
                    beat_d = beat_q + 2'd1;
                    if (last_beat) state_d = StDone;
                end
            end
            StRwait: begin
                if (iRd_Beat_Valid) begin
                    rd_buf_d[beat_q] = iRd_Beat_Data;
                    beat_d           = beat_q + 2'd1;
                    if (last_beat) state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (wd_expire) state_d = StDone;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            beat_q      <= '0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            align_err_q <= 1'b0;
            wr_words_q  <= '{default: '0};
            rd_buf_q    <= '{default: '0};
            rd_out_q    <= '{default: '0};
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            rd_buf_q <= rd_buf_d;
            if (accept) begin
                cmd_write_q <= grant_wr;
                cmd_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
                if (req_addr[1:0] != 2'b00) align_err_q <= 1'b1;
                if (grant_wr) wr_words_q <= '{iWr_Data1, iWr_Data2, iWr_Data3, iWr_Data4};
            end
            if (busy_run && (state_d == StDone) && !cmd_write_q) rd_out_q <= rd_buf_d;
        end
    end

    assign oBusy         = (state_q != StIdle);
    assign oCmd_Valid    = (state_q == StCmd);
    assign oCmd_Write    = cmd_write_q;
    assign oCmd_Addr     = cmd_addr_q;
    assign oWr_Beat_Data = (state_q == StWbeat) ? wr_words_q[beat_q] : '0;
    assign oRd_Done      = (state_q == StDone) && !cmd_write_q;
    assign oWr_Done      = (state_q == StDone) && cmd_write_q;
    assign oRd_Data1     = rd_out_q[0];
    assign oRd_Data2     = rd_out_q[1];
    assign oRd_Data3     = rd_out_q[2];
    assign oRd_Data4     = rd_out_q[3];
    assign oAlign_Err    = align_err_q;
endmodule

// File: tb/tb_sdram_burst_responder.sv
// Bench for sdram_burst_responder: directed scenarios, then randomized client/core traffic
// scored against a transaction-level model of the request/burst/done protocol.
module tb_sdram_burst_responder;
    import sdram_glue_pkg::*;

    localparam int unsigned AW = ADDR_W;
    localparam int unsigned DW = DATA_W;
    localparam int PH_IDLE = 0, PH_CMD = 1, PH_WR = 2, PH_RD = 3, PH_WR_END = 4, PH_RD_END = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          iRd_Req = 1'b0, iWr_Req = 1'b0;
    logic [AW-1:0] iRd_Addr = '0, iWr_Addr = '0;
    logic [DW-1:0] iWr_Data1 = '0, iWr_Data2 = '0, iWr_Data3 = '0, iWr_Data4 = '0;
    logic [DW-1:0] oRd_Data1, oRd_Data2, oRd_Data3, oRd_Data4;
    logic          oRd_Done, oWr_Done, oCmd_Valid, oCmd_Write, oBusy, oAlign_Err;
    logic [AW-1:0] oCmd_Addr;
    logic [DW-1:0] oWr_Beat_Data;
    logic          iCmd_Ready = 1'b0, iWr_Beat_Ready = 1'b0, iRd_Beat_Valid = 1'b0;
    logic [DW-1:0] iRd_Beat_Data = '0;
`ifdef SDRAM_RESP_TIMEOUT_EN
    logic          timeout_err;
`endif

    int unsigned n_checks = 0, n_pass = 0;

    // Transaction-level model state for the randomized phase.
    int            ph, beats, stuck;
    bit            last_wr, exp_wr, align_model;
    logic [AW-1:0] sel_addr, exp_addr;
    logic [DW-1:0] exp_words [4];
    logic [DW-1:0] exp_rd [4];
    logic [63:0]   rd_hold;

    always #5 clk = ~clk;

    sdram_burst_responder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .iRd_Req        (iRd_Req),
        .iRd_Addr       (iRd_Addr),
        .oRd_Data1      (oRd_Data1),
        .oRd_Data2      (oRd_Data2),
        .oRd_Data3      (oRd_Data3),
        .oRd_Data4      (oRd_Data4),
        .oRd_Done       (oRd_Done),
        .iWr_Req        (iWr_Req),
        .iWr_Addr       (iWr_Addr),
        .iWr_Data1      (iWr_Data1),
        .iWr_Data2      (iWr_Data2),
        .iWr_Data3      (iWr_Data3),
        .iWr_Data4      (iWr_Data4),
        .oWr_Done       (oWr_Done),
        .oCmd_Valid     (oCmd_Valid),
        .iCmd_Ready     (iCmd_Ready),
        .oCmd_Write     (oCmd_Write),
        .oCmd_Addr      (oCmd_Addr),
        .oWr_Beat_Data  (oWr_Beat_Data),
        .iWr_Beat_Ready (iWr_Beat_Ready),
        .iRd_Beat_Valid (iRd_Beat_Valid),
        .iRd_Beat_Data  (iRd_Beat_Data),
        .oBusy          (oBusy),
`ifdef SDRAM_RESP_TIMEOUT_EN
        .oTimeout_Err   (timeout_err),
`endif
        .oAlign_Err     (oAlign_Err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic chance(input int unsigned pct);
        return $urandom_range(0, 99) < pct;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = AW'($urandom);
        if ($urandom_range(0, 15) != 0) a[1:0] = 2'b00;
        return a;
    endfunction

    function automatic logic [63:0] rd_data_bus();
        return {oRd_Data1, oRd_Data2, oRd_Data3, oRd_Data4};
    endfunction

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] w0,
                            input logic [DW-1:0] w1, input logic [DW-1:0] w2,
                            input logic [DW-1:0] w3, input bit toggle, input bit exp_align);
        logic [DW-1:0] words [4];
        int got, cyc;
        words = '{w0, w1, w2, w3};
        iWr_Addr = addr;
        {iWr_Data1, iWr_Data2, iWr_Data3, iWr_Data4} = {w0, w1, w2, w3};
        iWr_Req = 1'b1;
        tick();
        check_eq("wr_cmd_valid", 64'(oCmd_Valid), 64'd1);
        check_eq("wr_cmd_write", 64'(oCmd_Write), 64'd1);
        check_eq("wr_cmd_addr", 64'(oCmd_Addr), 64'({addr[AW-1:2], 2'b00}));
        check_eq("wr_align", 64'(oAlign_Err), 64'(exp_align));
        iCmd_Ready = 1'b1;
        tick();
        iCmd_Ready = 1'b0;
        {iWr_Data1, iWr_Data2, iWr_Data3, iWr_Data4} = ~{w0, w1, w2, w3};
        got = 0;
        cyc = 0;
        while (got < 4 && cyc < 20) begin
            iWr_Beat_Ready = toggle ? 1'(cyc % 2 == 0) : 1'b1;
            if (iWr_Beat_Ready) begin
                check_eq("wr_beat_data", 64'(oWr_Beat_Data), 64'(words[got]));
                got++;
            end
            check_eq("wr_no_early_done", 64'(oWr_Done), 64'd0);
            tick();
            cyc++;
        end
        iWr_Beat_Ready = 1'b0;
        check_eq("wr_beats", 64'(got), 64'd4);
        check_eq("wr_done", 64'({oWr_Done, oRd_Done}), 64'b10);
        iWr_Req = 1'b0;
        tick();
        check_eq("wr_done_pulse", 64'(oWr_Done), 64'd0);
        check_eq("wr_align_after", 64'(oAlign_Err), 64'(exp_align));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (2) tick();
        check_eq("reset_rd_data", rd_data_bus(), 64'd0);
        check_eq("reset_ctrl", 64'({oRd_Done, oWr_Done, oCmd_Valid, oCmd_Write, oBusy, oAlign_Err,
                                    oCmd_Addr, oWr_Beat_Data}), 64'd0);
        rst_n = 1'b1;
        tick();

        // Read at ring base, core ready at once, back-to-back beats: Done at cycle 6.
        iRd_Addr = AW'(RING_BASE);
        iRd_Req  = 1'b1;
        tick();
        check_eq("rd_cmd_valid", 64'(oCmd_Valid), 64'd1);
        check_eq("rd_cmd_write", 64'(oCmd_Write), 64'd0);
        check_eq("rd_cmd_addr", 64'(oCmd_Addr), 64'(RING_BASE));
        iCmd_Ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            tick();
            iCmd_Ready     = 1'b0;
            iRd_Beat_Valid = 1'b1;
            iRd_Beat_Data  = 16'(16'h0011 * (b + 1));
            check_eq("rd_no_early_done", 64'(oRd_Done), 64'd0);
        end
        tick();
        iRd_Beat_Valid = 1'b0;
        check_eq("rd_done_cycle6", 64'({oRd_Done, oWr_Done}), 64'b10);
        check_eq("rd_data", rd_data_bus(), 64'h0011_0022_0033_0044);
        iRd_Req = 1'b0;
        tick();
        check_eq("rd_done_pulse", 64'(oRd_Done), 64'd0);

        do_write(24'd7212, 16'hF81F, 16'hF81F, 16'hF81F, 16'hF81F, 1'b1, 1'b0);
        do_write(24'd7213, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0, 1'b1);
        do_write(24'd7212, 16'h5555, 16'h6666, 16'h7777, 16'h8888, 1'b1, 1'b1);
        check_eq("rd_hold_after_wr", rd_data_bus(), 64'h0011_0022_0033_0044);

        // Reset in the middle of a read after two beats.
        iRd_Addr = AW'(RING_BASE + 8);
        iRd_Req  = 1'b1;
        tick();
        iCmd_Ready = 1'b1;
        tick();
        iCmd_Ready     = 1'b0;
        iRd_Beat_Valid = 1'b1;
        iRd_Beat_Data  = 16'hAAAA;
        tick();
        iRd_Beat_Data = 16'hBBBB;
        tick();
        iRd_Beat_Valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_rd_data", rd_data_bus(), 64'd0);
        check_eq("midrst_ctrl", 64'({oRd_Done, oWr_Done, oCmd_Valid, oCmd_Write, oBusy, oAlign_Err,
                                     oCmd_Addr, oWr_Beat_Data}), 64'd0);
        tick();
        check_eq("midrst_no_done", 64'({oRd_Done, oWr_Done}), 64'd0);

        // Randomized traffic; both requests are pending as reset releases.
        iRd_Req  = 1'b1;
        iWr_Req  = 1'b1;
        iRd_Addr = rand_addr();
        iWr_Addr = rand_addr();
        {iWr_Data1, iWr_Data2, iWr_Data3, iWr_Data4} = {$urandom, $urandom};
        ph          = PH_IDLE;
        last_wr     = 1'b0;
        align_model = 1'b0;
        rd_hold     = '0;
        stuck       = 0;
        beats       = 0;
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (ph == PH_IDLE && oCmd_Valid) begin
                check_eq("cmd_has_request", 64'(iRd_Req || iWr_Req), 64'd1);
                exp_wr   = (iRd_Req && iWr_Req) ? !last_wr : iWr_Req;
                last_wr  = exp_wr;
                sel_addr = exp_wr ? iWr_Addr : iRd_Addr;
                exp_addr = {sel_addr[AW-1:2], 2'b00};
                if (sel_addr[1:0] != 2'b00) align_model = 1'b1;
                exp_words = '{iWr_Data1, iWr_Data2, iWr_Data3, iWr_Data4};
                ph = PH_CMD;
            end

            check_eq("busy", 64'(oBusy), 64'(ph != PH_IDLE));
            check_eq("rd_done_flag", 64'(oRd_Done), 64'(ph == PH_RD_END));
            check_eq("wr_done_flag", 64'(oWr_Done), 64'(ph == PH_WR_END));
            check_eq("align_sticky", 64'(oAlign_Err), 64'(align_model));
            check_eq("rd_data_bus", rd_data_bus(),
                     (ph == PH_RD_END) ? {exp_rd[0], exp_rd[1], exp_rd[2], exp_rd[3]} : rd_hold);
            check_eq("cmd_valid", 64'(oCmd_Valid), 64'(ph == PH_CMD));
            if (ph == PH_CMD)
                check_eq("cmd_fields", {39'd0, oCmd_Write, oCmd_Addr}, {39'd0, exp_wr, exp_addr});
            if (ph == PH_WR) check_eq("beat_data", 64'(oWr_Beat_Data), 64'(exp_words[beats]));

            if (ph == PH_RD_END) begin
                rd_hold = {exp_rd[0], exp_rd[1], exp_rd[2], exp_rd[3]};
                iRd_Req = 1'b0;
                ph      = PH_IDLE;
                stuck   = 0;
            end else if (ph == PH_WR_END) begin
                iWr_Req = 1'b0;
                ph      = PH_IDLE;
                stuck   = 0;
            end

            // Core side: noise on signals the responder must ignore outside their phase.
            iCmd_Ready     = chance(50);
            iWr_Beat_Ready = chance(50);
            iRd_Beat_Valid = chance(50);
            iRd_Beat_Data  = DW'($urandom);
            case (ph)
                PH_CMD: begin
                    iCmd_Ready = chance(60);
                    if (iCmd_Ready) begin
                        ph    = exp_wr ? PH_WR : PH_RD;
                        beats = 0;
                    end
                end
                PH_WR: begin
                    iWr_Beat_Ready = chance(65);
                    if (iWr_Beat_Ready) begin
                        beats++;
                        if (beats == 4) ph = PH_WR_END;
                    end
                end
                PH_RD: begin
                    iRd_Beat_Valid = chance(65);
                    if (iRd_Beat_Valid) begin
                        exp_rd[beats] = iRd_Beat_Data;
                        beats++;
                        if (beats == 4) ph = PH_RD_END;
                    end
                end
                default: iCmd_Ready = (ph == PH_IDLE) ? iCmd_Ready : 1'b0;
            endcase

            // Client side: raise requests at random, scramble everything not yet captured.
            if (!iRd_Req && chance(25)) iRd_Req = 1'b1;
            if (!iWr_Req && chance(25)) iWr_Req = 1'b1;
            iRd_Addr = rand_addr();
            iWr_Addr = rand_addr();
            {iWr_Data1, iWr_Data2, iWr_Data3, iWr_Data4} = {$urandom, $urandom};

            if (iRd_Req || iWr_Req || ph != PH_IDLE) stuck++;
            if (stuck > 400) begin
                check_eq("progress_bound", 64'(stuck), 64'd0);
                break;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
